n_voter_reg: RTL and testbench
==============================

Name: n_voter_reg

Overview:
- Registered, parametrised N-channel, WIDTH-bit bitwise majority voter; successor to the 3-input single-bit combinational voter.
- Samples redundant channel words on a valid strobe and outputs the voted word one cycle later.
- Tracks per-channel persistent disagreement and raises sticky per-channel fault flags.
- Sits between triplicated or redundant datapaths and downstream consumers.

Parameters:
- N, 3: channel count; must be odd and >= 3; otherwise elaboration fails.
- WIDTH, 8: bits per channel.
- FAULT_THRESH, 4: consecutive disagreeing valid samples that latch a channel fault; range 1..255.
- CNT_W, 8: width of the per-channel persistence counter; must satisfy 2^CNT_W - 1 >= FAULT_THRESH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in_data for one cycle.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- mode  input  1  0 = majority; 1 = unanimous-hold.
- clr_fault  input  1  one-cycle pulse; clears all counters and fault flags.
- out_valid  output  1  registered; high one cycle after each accepted in_valid.
- out_data  output  WIDTH  registered voted word.
- agree  output  1  registered; all N channels were identical for the sample.
- fault  output  N  sticky per-channel fault flags.

Behaviour:
- Reset values (async):
  - out_valid = 0, out_data = 0, agree = 0, fault = 0.
  - All persistence counters = 0.
  - Channel FSMs in OK.
- Vote:
  - Per bit position, the result is 1 iff the count of ones across the N channels is >= (N+1)/2.
  - Popcount width is clog2(N+1).
- Latency:
  - in_valid at edge t gives out_valid = 1 at edge t+1, with out_data and agree for that sample.
  - Back-to-back in_valid is supported, one result per cycle; there is no backpressure.
- mode = 0: out_data takes the majority word on every accepted sample.
- mode = 1:
  - out_data takes the word only when all channels agree.
  - Otherwise out_data holds its previous value, out_valid still pulses, and agree = 0.
- When in_valid = 0:
  - out_valid = 0.
  - out_data, agree, counters and fault are unchanged.
- Disagreement: channel k disagrees when in_data[k] != majority word, evaluated in both modes.
- Channel FSM (per k), updated only on in_valid:
  - OK: disagree -> counter = 1, go to SUSPECT; agree -> stay, counter = 0.
  - SUSPECT: disagree -> counter + 1; when the incremented count equals FAULT_THRESH, go to FAULT and set fault[k]. Agree -> counter = 0, go to OK.
  - FAULT: sticky; counter saturates at FAULT_THRESH; fault[k] = 1 until clr_fault or rst.
  - FAULT_THRESH = 1 means the first disagreement goes straight from OK to FAULT.
- clr_fault:
  - Synchronous; all FSMs go to OK, counters = 0, fault = 0.
  - Coincident with in_valid: the clear wins for FSMs and counters, and that sample does not count toward disagreement. The vote and output path still process the sample normally.
- Reset mid-stream: any in-flight result is discarded and out_valid = 0 immediately.
- The fault flags are informational; faulted channels still participate in the vote.

Optional Feature:
- Macro VOTER_STATS_EN.
- Defined:
  - Adds output mismatch_cnt, 16 bits.
  - Counts accepted samples with agree = 0, saturating at 16'hFFFF.
  - Reset to 0 by rst and by clr_fault.
  - When clr_fault coincides with in_valid, the clear wins.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package voter_pkg holds:
  - Channel FSM enum typedef (OK, SUSPECT, FAULT).
  - localparam MODE_MAJ = 1'b0, MODE_UNAN = 1'b1.
  - Stats counter width constant STATS_W = 16.
- One combinational sub-module, vote_core:
  - Takes the N*WIDTH input.
  - Produces the majority word, the per-channel disagree vector and all_equal.
- n_voter_reg instantiates vote_core plus the registers and FSMs.

Test Plan (N=3, WIDTH=4, FAULT_THRESH=4):
1. Reset then a single sample, channels 0xA, 0xA, 0x3, mode 0 -> next cycle out_valid = 1, out_data = 0xA, agree = 0; fault = 000.
2. Bitwise vote, channels 0xC, 0xA, 0x6 -> out_data = 0xE; all three channels disagree; counters = 1 each.
3. Channel 2 = 0x5 while channels 0/1 = 0x0, on 4 consecutive valids -> fault = 100 after the 4th sample's edge, not the 3rd. A 5th sample with agreement leaves fault = 100 (sticky).
4. Channel 1 disagrees on 3 samples, agrees on 1, disagrees on 3 -> fault[1] stays 0 (counter resets on agreement).
5. mode 1: an agreeing sample 0x7 then a mismatching sample 0x7, 0x7, 0x1 -> out_data = 0x7 then holds 0x7, agree 1 then 0, out_valid pulses both times. Follow with 0x2 on all channels -> out_data = 0x2.
6. With fault = 100 asserted, pulse clr_fault coincident with a disagreeing sample -> fault = 000, counter[2] = 0, out_data still updated. Assert rst mid-burst -> out_valid drops immediately.

Source files
------------

// File: rtl/voter_pkg.sv
// Shared types and constants for the registered N-channel majority voter.
package voter_pkg;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2
  } ch_state_e;

  localparam logic MODE_MAJ  = 1'b0;
  localparam logic MODE_UNAN = 1'b1;

  localparam int STATS_W = 16;

endpackage

// File: rtl/vote_core.sv
// Combinational bitwise majority over N channels, plus per-channel disagree and all-equal.
module vote_core #(
  parameter int N     = 3,
  parameter int WIDTH = 8
) (
  input  logic [N*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]   maj,
  output logic [N-1:0]       disagree,
  output logic               all_equal
);

  localparam int PC_W = $clog2(N + 1);
  localparam logic [PC_W-1:0] HALF = PC_W'((N + 1) / 2);

  logic [PC_W-1:0] pc;

  always_comb begin
    maj = '0;
    pc  = '0;
    for (int b = 0; b < WIDTH; b++) begin
      pc = '0;
      for (int k = 0; k < N; k++)
        pc = pc + PC_W'(in_data[k*WIDTH + b]);
      maj[b] = (pc >= HALF);
    end
  end

  always_comb begin
    disagree = '0;
    for (int k = 0; k < N; k++)
      disagree[k] = (in_data[k*WIDTH +: WIDTH] != maj);
  end

  // No channel differing from the majority means every channel is identical.
  assign all_equal = ~|disagree;

endmodule

// File: rtl/n_voter_reg.sv
// Registered N-channel majority voter with per-channel persistent-disagreement fault tracking.
// Optional VOTER_STATS_EN adds a saturating mismatch_cnt output.
module n_voter_reg
  import voter_pkg::*;
#(
  parameter int N            = 3,
  parameter int WIDTH        = 8,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               mode,
  input  logic               clr_fault,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               agree,
`ifdef VOTER_STATS_EN
  output logic [STATS_W-1:0] mismatch_cnt,
`endif
  output logic [N-1:0]       fault
);

  if (N < 3 || (N % 2) == 0) begin : g_bad_n
    $error("n_voter_reg: N must be odd and >= 3");
  end
  if (FAULT_THRESH < 1 || FAULT_THRESH > 255) begin : g_bad_thresh
    $error("n_voter_reg: FAULT_THRESH must be in 1..255");
  end
  if (((1 << CNT_W) - 1) < FAULT_THRESH) begin : g_bad_cnt_w
    $error("n_voter_reg: CNT_W too narrow for FAULT_THRESH");
  end

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  logic [WIDTH-1:0] maj;
  logic [N-1:0]     disagree;
  logic             all_equal;

  vote_core #(.N(N), .WIDTH(WIDTH)) u_core (
    .in_data   (in_data),
    .maj       (maj),
    .disagree  (disagree),
    .all_equal (all_equal)
  );

  // Output path: unanimous-hold keeps the last clean word when channels split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      agree     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        agree <= all_equal;
        if (mode == MODE_MAJ || all_equal)
          out_data <= maj;
      end
    end
  end

  ch_state_e              st  [N];
  logic [N-1:0][CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) st[k] <= OK;
      cnt   <= '0;
      fault <= '0;
    end else if (clr_fault) begin
      for (int k = 0; k < N; k++) st[k] <= OK;
      cnt   <= '0;
      fault <= '0;
    end else if (in_valid) begin
      for (int k = 0; k < N; k++) begin
        case (st[k])
          OK: begin
            if (disagree[k]) begin
              cnt[k] <= CNT_W'(1);
              if (THRESH == CNT_W'(1)) begin
                st[k]    <= FAULT;
                fault[k] <= 1'b1;
              end else begin
                st[k] <= SUSPECT;
              end
            end else begin
              cnt[k] <= '0;
            end
          end
          SUSPECT: begin
            if (disagree[k]) begin
              cnt[k] <= cnt[k] + CNT_W'(1);
              if (cnt[k] + CNT_W'(1) == THRESH) begin
                st[k]    <= FAULT;
                fault[k] <= 1'b1;
              end
            end else begin
              cnt[k] <= '0;
              st[k]  <= OK;
            end
          end
          FAULT: begin
            // Sticky until cleared; counter parks at the threshold.
            cnt[k]   <= THRESH;
            fault[k] <= 1'b1;
          end
          default: begin
            st[k]  <= OK;
            cnt[k] <= '0;
          end
        endcase
      end
    end
  end

`ifdef VOTER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mismatch_cnt <= '0;
    else if (clr_fault)
      mismatch_cnt <= '0;
    else if (in_valid && !all_equal && mismatch_cnt != {STATS_W{1'b1}})
      mismatch_cnt <= mismatch_cnt + STATS_W'(1);
  end
`endif

endmodule

// File: tb/tb_n_voter_reg.sv
// Directed bench for n_voter_reg at N=3, WIDTH=4, FAULT_THRESH=4.
module tb_n_voter_reg;
  localparam int N = 3;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [N*W-1:0] in_data;
  logic           mode;
  logic           clr_fault;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           agree;
  logic [N-1:0]   fault;
`ifdef VOTER_STATS_EN
  logic [15:0]    mismatch_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  n_voter_reg #(.N(N), .WIDTH(W), .FAULT_THRESH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .mode         (mode),
    .clr_fault    (clr_fault),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .agree        (agree),
`ifdef VOTER_STATS_EN
    .mismatch_cnt (mismatch_cnt),
`endif
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the following rising edge.
  task automatic step(input logic v, input logic [3:0] c0, input logic [3:0] c1,
                      input logic [3:0] c2, input logic m, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = {c2, c1, c0};
    mode      = m;
    clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; clr_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_od", 32'(out_data), 32'h0);
    chk("rst_ag", 32'(agree), 32'd0);
    chk("rst_flt", 32'(fault), 32'h0);
    @(negedge clk); rst = 1'b0;

    // 1: simple majority
    step(1, 4'hA, 4'hA, 4'h3, 0, 0);
    chk("t1_ov", 32'(out_valid), 32'd1);
    chk("t1_od", 32'(out_data), 32'hA);
    chk("t1_ag", 32'(agree), 32'd0);
    chk("t1_flt", 32'(fault), 32'h0);
    step(0, 4'h0, 4'h0, 4'h0, 0, 0);
    chk("idle_ov", 32'(out_valid), 32'd0);
    chk("idle_od", 32'(out_data), 32'hA);

    // 2: bitwise vote across three different words
    step(1, 4'hC, 4'hA, 4'h6, 0, 0);
    chk("t2_od", 32'(out_data), 32'hE);
    chk("t2_ag", 32'(agree), 32'd0);
    step(0, 4'h0, 4'h0, 4'h0, 0, 1);
    chk("t2_clr_flt", 32'(fault), 32'h0);

    // 3: channel 2 persistent disagreement latches on the 4th sample
    for (int i = 1; i <= 4; i++) begin
      step(1, 4'h0, 4'h0, 4'h5, 0, 0);
      chk($sformatf("t3_flt_%0d", i), 32'(fault), (i == 4) ? 32'h4 : 32'h0);
    end
    step(1, 4'h0, 4'h0, 4'h0, 0, 0);
    chk("t3_sticky", 32'(fault), 32'h4);
    chk("t3_ag", 32'(agree), 32'd1);
    chk("t3_od", 32'(out_data), 32'h0);

    // 4: interrupted disagreement on channel 1 never faults
    for (int i = 0; i < 7; i++) begin
      if (i == 3) step(1, 4'h0, 4'h0, 4'h0, 0, 0);
      else        step(1, 4'h0, 4'h1, 4'h0, 0, 0);
      chk($sformatf("t4_flt_%0d", i), 32'(fault), 32'h4);
    end

    // 5: unanimous-hold
    step(1, 4'h7, 4'h7, 4'h7, 1, 0);
    chk("t5a_ov", 32'(out_valid), 32'd1);
    chk("t5a_od", 32'(out_data), 32'h7);
    chk("t5a_ag", 32'(agree), 32'd1);
    step(1, 4'h7, 4'h7, 4'h1, 1, 0);
    chk("t5b_ov", 32'(out_valid), 32'd1);
    chk("t5b_od", 32'(out_data), 32'h7);
    chk("t5b_ag", 32'(agree), 32'd0);
    step(1, 4'h2, 4'h2, 4'h2, 1, 0);
    chk("t5c_od", 32'(out_data), 32'h2);

    // 6: clear coincident with a disagreeing sample; sample still voted, not counted
    step(1, 4'h0, 4'h0, 4'h5, 0, 1);
    chk("t6_flt", 32'(fault), 32'h0);
    chk("t6_od", 32'(out_data), 32'h0);
    chk("t6_ov", 32'(out_valid), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 4'h0, 4'h0, 4'h5, 0, 0);
      chk($sformatf("t6_cnt_%0d", i), 32'(fault), (i == 4) ? 32'h4 : 32'h0);
    end

    // Reset mid-burst: output valid drops without waiting for an edge
    step(1, 4'h9, 4'h9, 4'h9, 0, 0);
    chk("t6_burst_ov", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ov", 32'(out_valid), 32'd0);
    chk("t6_rst_od", 32'(out_data), 32'h0);
    chk("t6_rst_flt", 32'(fault), 32'h0);
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ov", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
